// File: rtl/fifo_issue_scheduler.sv
// Pops instructions from two FIFOs with weighted round-robin and issues them one
// at a time on a valid/ready execute port, throttled by an outstanding counter.
module fifo_issue_scheduler #(
  parameter int DATA_W  = 32,
  parameter int WEIGHT  = 2,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo1_empty,
  input  logic [DATA_W-1:0] fifo1_data,
  output logic              fifo1_rd_en,
  input  logic              fifo2_empty,
  input  logic [DATA_W-1:0] fifo2_data,
  output logic              fifo2_rd_en,
  output logic              exe_valid,
  output logic [DATA_W-1:0] exe_instr,
  output logic              exe_src,
  input  logic              exe_ready,
  input  logic              exe_done,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_underflow
);
  localparam int SW = $clog2(WEIGHT + 1);
  localparam logic [SW-1:0]    WEIGHT_C = SW'(WEIGHT);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, READ, WAIT, ISSUE} state_t;

  state_t        state, state_next;
  logic          sel;
  logic          last;
  logic [SW-1:0] streak;
  logic          grant;
  logic          can_start;
  logic          handshake;
  logic          done_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (can_start) state_next = READ;
      READ:    state_next = WAIT;
      WAIT:    state_next = ISSUE;
      ISSUE:   if (exe_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo1_rd_en = (state == READ) && !sel;
    fifo2_rd_en = (state == READ) && sel;
    exe_valid   = (state == ISSUE);
  end

  // With a single non-empty lane, fifo1_empty alone names it.
  always_comb begin
    if (!fifo1_empty && !fifo2_empty) grant = (streak == WEIGHT_C) ? ~last : last;
    else                              grant = fifo1_empty;
  end

  assign can_start = (!fifo1_empty || !fifo2_empty) && (outstanding < MAX_C);
  assign handshake = (state == ISSUE) && exe_ready;
  assign done_ok   = exe_done && (outstanding != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= 1'b0;
      exe_instr <= '0;
      exe_src   <= 1'b0;
    end else begin
      if (state == IDLE && can_start) sel <= grant;
      if (state == WAIT) begin
        exe_instr <= sel ? fifo2_data : fifo1_data;
        exe_src   <= sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last   <= 1'b0;
      streak <= '0;
    end else if (handshake) begin
      if (sel == last) begin
        if (streak != WEIGHT_C) streak <= streak + SW'(1);
      end else begin
        last   <= sel;
        streak <= SW'(1);
      end
    end
  end

  // A completion arriving with nothing outstanding is ignored and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (handshake && !done_ok)      outstanding <= outstanding + CNT_W'(1);
      else if (!handshake && done_ok) outstanding <= outstanding - CNT_W'(1);
      if (exe_done && outstanding == '0) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_issue_scheduler.sv
// Self-checking bench for fifo_issue_scheduler: FIFO models, a transaction-level
// reference model, a per-cycle compare process, directed and random phases.
module tb_fifo_issue_scheduler;
  localparam int DATA_W = 32, WEIGHT = 2, MAX_OUT = 4, CNT_W = 3;
  localparam int M_IDLE = 0, M_READ = 1, M_WAIT = 2, M_ISSUE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo1_empty, fifo2_empty;
  logic [DATA_W-1:0] fifo1_data = '0, fifo2_data = '0;
  logic              fifo1_rd_en, fifo2_rd_en;
  logic              exe_valid, exe_src;
  logic [DATA_W-1:0] exe_instr;
  logic              exe_ready = 1'b0;
  logic              exe_done = 1'b0;
  logic [CNT_W-1:0]  outstanding;
  logic              err_underflow;

  int n_chk = 0, n_fail = 0;

  // FIFO storage: main writes entries, the FIFO process consumes them
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem2 [0:4095];
  int push1 = 0, push2 = 0, pops1 = 0, pops2 = 0, rd_cnt = 0;
  assign fifo1_empty = (push1 == pops1);
  assign fifo2_empty = (push2 == pops2);

  // Reference model state
  int          m_phase = M_IDLE, m_out = 0, m_streak = 0, m_rd1 = 0, m_rd2 = 0;
  bit          m_sel = 0, m_last = 0, m_err = 0, m_hs, m_dn, m_e1, m_e2;
  logic [31:0] m_item = '0;
  bit          m_log[$];
  bit          dut_log[$];

  int done_mode = 0;
  bit done_req = 0;

  always #5 clk = ~clk;

  fifo_issue_scheduler #(.DATA_W(DATA_W), .WEIGHT(WEIGHT), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .fifo1_empty(fifo1_empty), .fifo1_data(fifo1_data), .fifo1_rd_en(fifo1_rd_en),
    .fifo2_empty(fifo2_empty), .fifo2_data(fifo2_data), .fifo2_rd_en(fifo2_rd_en),
    .exe_valid(exe_valid), .exe_instr(exe_instr), .exe_src(exe_src),
    .exe_ready(exe_ready), .exe_done(exe_done),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit lane, input logic [31:0] v);
    if (lane) begin mem2[push2] = v; push2++; end
    else      begin mem1[push1] = v; push1++; end
  endtask

  // FIFO read side: data appears the cycle after the pop strobe
  initial forever begin
    @(posedge clk);
    if (fifo1_rd_en) begin fifo1_data <= mem1[pops1]; pops1 <= pops1 + 1; rd_cnt <= rd_cnt + 1; end
    if (fifo2_rd_en) begin fifo2_data <= mem2[pops2]; pops2 <= pops2 + 1; rd_cnt <= rd_cnt + 1; end
    if (!reset && exe_valid && exe_ready) dut_log.push_back(exe_src);
  end

  // Reference model: one decision, one pop, then an offer held until accepted
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_phase = M_IDLE; m_last = 0; m_streak = 0; m_out = 0; m_err = 0; m_sel = 0;
    end else begin
      m_hs = (m_phase == M_ISSUE) && exe_ready;
      m_dn = exe_done;
      case (m_phase)
        M_IDLE: begin
          m_e1 = push1 > m_rd1;
          m_e2 = push2 > m_rd2;
          if (m_out < MAX_OUT && (m_e1 || m_e2)) begin
            if (m_e1 && m_e2) m_sel = (m_streak < WEIGHT) ? m_last : !m_last;
            else              m_sel = m_e2;
            m_phase = M_READ;
          end
        end
        M_READ: begin
          if (m_sel) begin m_item = mem2[m_rd2]; m_rd2++; end
          else       begin m_item = mem1[m_rd1]; m_rd1++; end
          m_phase = M_WAIT;
        end
        M_WAIT: m_phase = M_ISSUE;
        default: if (m_hs) begin
          m_log.push_back(m_sel);
          if (m_sel == m_last) begin
            if (m_streak < WEIGHT) m_streak++;
          end else begin
            m_last = m_sel; m_streak = 1;
          end
          m_phase = M_IDLE;
        end
      endcase
      if (m_dn && m_out == 0) m_err = 1;
      m_out = m_out + (m_hs ? 1 : 0) - ((m_dn && m_out > 0) ? 1 : 0);
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(posedge clk);
    #2;
    if (!reset) begin
      chk("rd_en1", fifo1_rd_en, (m_phase == M_READ) && !m_sel);
      chk("rd_en2", fifo2_rd_en, (m_phase == M_READ) && m_sel);
      chk("exe_valid", exe_valid, m_phase == M_ISSUE);
      if (m_phase == M_ISSUE) begin
        chk("exe_instr", exe_instr, m_item);
        chk("exe_src", exe_src, m_sel);
      end
      chk("outstanding", outstanding, m_out);
      chk("err_underflow", err_underflow, m_err);
    end
  end

  // Completion driver: manual pulses, auto-return, or random return
  initial forever begin
    @(negedge clk);
    #1;
    case (done_mode)
      0:       exe_done = done_req;
      1:       exe_done = (m_out > 0);
      default: exe_done = (m_out > 0) && ($urandom_range(0, 2) == 0);
    endcase
  end

  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    while (cycles < max) begin
      @(posedge clk); #2;
      cycles++;
      if (exe_valid) break;
    end
    chk("wait_valid_timeout", exe_valid, 1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    exe_ready = 1;
    done_mode = 1;
    while (n < max && !(m_phase == M_IDLE && m_out == 0 && push1 == m_rd1 && push2 == m_rd2)) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_timeout", n < max, 1);
    @(negedge clk);
    done_mode = 0;
    done_req = 0;
  endtask

  initial begin
    int cyc, base, dbase, rc, n;
    for (int i = 0; i < 4096; i++) begin mem1[i] = '0; mem2[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_valid", exe_valid, 0);
    chk("rst_instr", exe_instr, 0);
    chk("rst_src", exe_src, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_rd_en", {fifo1_rd_en, fifo2_rd_en}, 0);
    reset = 0;

    // Single instruction through FIFO_1
    @(negedge clk);
    exe_ready = 1;
    rc = rd_cnt;
    push(0, 32'h0000_1001);
    wait_valid(10, cyc);
    chk("single_latency", cyc, 3);
    chk("single_instr", exe_instr, 32'h0000_1001);
    chk("single_src", exe_src, 0);
    chk("single_rd_pulses", rd_cnt - rc, 1);
    @(posedge clk); #2;
    chk("single_out_after_hs", outstanding, 1);
    @(negedge clk); done_req = 1;
    @(posedge clk); #2;
    chk("single_out_after_done", outstanding, 0);
    @(negedge clk); done_req = 0;

    // Weighted fairness from a fresh arbitration state
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    for (int i = 0; i < 6; i++) begin
      push(0, 32'h1000_0000 + i);
      push(1, 32'h2000_0000 + i);
    end
    base = m_log.size();
    dbase = dut_log.size();
    done_mode = 1;
    n = 0;
    while (n < 200 && m_log.size() < base + 12) begin @(posedge clk); #2; n++; end
    chk("fair_model_count", m_log.size() - base, 12);
    chk("fair_dut_count", dut_log.size() - dbase, 12);
    if (m_log.size() >= base + 12 && dut_log.size() >= dbase + 12)
      for (int i = 0; i < 12; i++) begin
        chk("fair_model_order", m_log[base + i], (i / 2) % 2);
        chk("fair_dut_order", dut_log[dbase + i], (i / 2) % 2);
      end
    drain(200);

    // Backpressure
    exe_ready = 0;
    push(1, 32'hB000_0001);
    dbase = dut_log.size();
    wait_valid(10, cyc);
    rc = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_valid", exe_valid, 1);
      chk("bp_instr", exe_instr, 32'hB000_0001);
      chk("bp_src", exe_src, 1);
      chk("bp_no_rd", rd_cnt - rc, 0);
    end
    @(negedge clk); exe_ready = 1;
    @(posedge clk); #2;
    chk("bp_release_valid", exe_valid, 0);
    chk("bp_one_issue", dut_log.size() - dbase, 1);
    chk("bp_outstanding", outstanding, 1);
    drain(100);

    // Outstanding limit without completions
    rc = rd_cnt;
    for (int i = 0; i < 6; i++) push(0, 32'hC000_0000 + i);
    repeat (40) @(negedge clk);
    chk("limit_outstanding", outstanding, 4);
    chk("limit_rd_pulses", rd_cnt - rc, 4);
    done_req = 1;
    @(negedge clk); done_req = 0;
    wait_valid(12, cyc);
    chk("limit_fifth_rd", rd_cnt - rc, 5);
    @(negedge clk); done_req = 1;
    @(posedge clk); #2;
    chk("limit_done_and_hs", outstanding, 3);
    @(negedge clk); done_req = 0;
    repeat (20) @(negedge clk);
    chk("limit_refill", outstanding, 4);
    chk("limit_sixth_rd", rd_cnt - rc, 6);
    drain(100);

    // Underflow
    done_req = 1;
    @(posedge clk); #2;
    chk("uf_err", err_underflow, 1);
    chk("uf_outstanding", outstanding, 0);
    @(negedge clk); done_req = 0;
    repeat (3) @(negedge clk);
    chk("uf_err_sticky", err_underflow, 1);

    // Reset while the second of two pops is in WAIT
    exe_ready = 1;
    push(0, 32'hD000_0001);
    push(0, 32'hD000_0002);
    n = 0;
    while (n < 30 && !(m_phase == M_WAIT && m_out == 1)) begin @(posedge clk); #2; n++; end
    chk("rst_mid_reach_wait", n < 30, 1);
    @(negedge clk); reset = 1;
    #1;
    chk("rst_mid_valid", exe_valid, 0);
    chk("rst_mid_outstanding", outstanding, 0);
    chk("rst_mid_err", err_underflow, 0);
    chk("rst_mid_instr", exe_instr, 0);
    chk("rst_mid_rd_en", {fifo1_rd_en, fifo2_rd_en}, 0);
    @(negedge clk); reset = 0;
    @(negedge clk);
    push(0, 32'hE000_0002);
    push(1, 32'hF000_0003);
    wait_valid(10, cyc);
    chk("rst_mid_next_instr", exe_instr, 32'hE000_0002);
    chk("rst_mid_next_src", exe_src, 0);
    drain(100);

    // Random traffic
    done_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      exe_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) push(0, {8'hA1, 24'(c)});
      if ($urandom_range(0, 3) == 0) push(1, {8'hA2, 24'(c)});
    end
    drain(3000);
    chk("final_fifo1_consumed", pops1, push1);
    chk("final_fifo2_consumed", pops2, push2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule

// File: doc/fifo_issue_scheduler.md
# fifo_issue_scheduler

Sequences the read side of the two instruction FIFOs fed by the arbiter (FIFO_1, FIFO_2) onto the single shared execute port. It pops one instruction at a time with weighted round-robin between the two queues. It presents the instruction to the execute stage with a valid/ready handshake. It throttles issue by counting issued-but-not-completed instructions.

## Interface
- DATA_W, 32, instruction width
- WEIGHT, 2, max consecutive grants to one FIFO while the other is non-empty (≥1)
- MAX_OUT, 4, max outstanding (issued, not yet done) instructions (≥1)
- CNT_W, 3, width of outstanding counter; must hold MAX_OUT

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fifo1_empty  in  1  FIFO_1 empty flag
- fifo1_data  in  DATA_W  FIFO_1 read data, valid the cycle after fifo1_rd_en
- fifo1_rd_en  out  1  one-cycle pop strobe to FIFO_1
- fifo2_empty, fifo2_data, fifo2_rd_en  same as FIFO_1, for FIFO_2
- exe_valid  out  1  exe_instr/exe_src valid
- exe_instr  out  DATA_W  instruction to execute stage
- exe_src  out  1  0 = from FIFO_1, 1 = from FIFO_2
- exe_ready  in  1  execute stage accepts when high with exe_valid
- exe_done  in  1  one-cycle completion pulse, one per issued instruction
- outstanding  out  CNT_W  current outstanding count
- err_underflow  out  1  sticky: exe_done seen with outstanding == 0

## Operation
- FSM states: IDLE → READ → WAIT → ISSUE → IDLE.
- IDLE: a lane is eligible when its empty flag is low. If no lane is eligible, or outstanding == MAX_OUT, stay in IDLE. Otherwise latch the chosen lane into sel, go to READ, and register that lane's rd_en high.
- READ: rd_en high for exactly this cycle. Go to WAIT and drop rd_en.
- WAIT: FIFO data for sel is valid. At the end of the cycle, capture it into exe_instr, set exe_src = sel, set exe_valid = 1, and go to ISSUE.
- ISSUE: hold exe_valid, exe_instr and exe_src stable until exe_ready = 1. On the handshake, clear exe_valid, increment the issue count, update the arbitration state, and go to IDLE.
- Arbitration state is last (lane granted at last issue, reset 0) and streak (consecutive grants to last, reset 0, saturating at WEIGHT).
  - Only one lane eligible: grant it.
  - Both eligible and streak < WEIGHT: grant last.
  - Both eligible and streak == WEIGHT: grant the other lane.
  - On handshake: if the granted lane == last, streak++; else last = granted and streak = 1.
- Outstanding counter:
  - +1 on issue handshake, −1 on exe_done; both in the same cycle leaves it unchanged.
  - exe_done with outstanding == 0: no change, set err_underflow (cleared only by reset).
- rd_en is never asserted to a lane that was empty in the deciding IDLE cycle. At most one rd_en is high in any cycle.

## Timing
- Reset values: fifo1_rd_en = fifo2_rd_en = 0, exe_valid = 0, exe_instr = 0, exe_src = 0, outstanding = 0, err_underflow = 0, state IDLE, last = 0, streak = 0.
- Latency: IDLE decision in cycle N → rd_en high in cycle N+1 → data captured at the end of N+2 → exe_valid high from cycle N+3.
- Minimum issue period is 4 cycles per instruction, with exe_ready held high.
- The outstanding limit is checked only in IDLE. Issue stalls while outstanding == MAX_OUT and resumes in the IDLE cycle after the exe_done that lowers it.
- Asynchronous reset in READ, WAIT or ISSUE abandons the popped instruction (it is not re-issued). All outputs go to their reset values immediately.
- A FIFO that becomes non-empty while the FSM is out of IDLE is considered at the next IDLE cycle.

## Test plan
- Single instruction: FIFO_1 holds 32'h0000_1001, FIFO_2 empty → fifo1_rd_en one pulse; exe_valid 3 cycles after the decision with exe_instr = 32'h0000_1001, exe_src = 0; outstanding = 1 after the handshake; exe_done returns it to 0.
- Weighted fairness, WEIGHT = 2: both FIFOs hold 6 entries, exe_ready = 1, exe_done returned each issue → exe_src order 0,0,1,1,0,0,1,1,0,0,1,1.
- Backpressure: exe_ready low for 5 cycles in ISSUE → exe_valid, exe_instr and exe_src stable all 5 cycles; no rd_en pulses; exactly one issue on release.
- Outstanding limit, MAX_OUT = 4, no exe_done: after 4 issues, outstanding = 4 and no further rd_en. One exe_done pulse leads to a 5th issue. A simultaneous exe_done and handshake keeps the count unchanged.
- Underflow: exe_done with outstanding = 0 → err_underflow = 1 and stays 1; outstanding stays 0.
- Reset mid-operation: assert reset during WAIT → exe_valid = 0, outstanding = 0, state IDLE, last = 0 immediately. After release, the next entry is popped normally.
